// File: rtl/mmio_stress_pkg.sv
// Shared types and LFSR helpers for the MMIO stress requesters.
// Holds the MMIO length encoding, the outstanding-read slot record and the data LFSR polynomial.
package mmio_stress_pkg;

    typedef enum logic [1:0] {
        LEN32 = 2'b00,
        LEN64 = 2'b01
    } t_mmio_len;

    typedef struct packed {
        logic       valid;
        logic [8:0] tid;
        t_mmio_len  len;
        logic [63:0] exp_data;
    } t_slot;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_DRAIN,
        ST_DONE
    } t_req_state;

    // Galois mask for x^64 + x^63 + x^61 + x^60 + 1 in right-shift form.
    localparam logic [63:0] LFSR_POLY = 64'hD800_0000_0000_0000;

    function automatic logic [63:0] lfsrStep(input logic [63:0] cur);
        return {1'b0, cur[63:1]} ^ (cur[0] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/mmio_stress_lfsr.sv
// 64-bit Galois LFSR: reloads SEED on reset and steps once per cycle when advance is high.
// Shared by the MMIO and DMA stress requesters.
module mmio_stress_lfsr
    import mmio_stress_pkg::*;
#(
    parameter logic [63:0] SEED = 64'h1
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic        advance,
    output logic [63:0] value
);

    if (SEED == 64'h0) begin : g_bad_seed
        $error("mmio_stress_lfsr: SEED must be nonzero");
    end

    // NOTE: sequential state is written with <= so every flop samples the pre-edge values.
    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsrStep(value);
        end
    end

endmodule

// File: rtl/mmio_stress_requester.sv
// CCI-P MMIO stress initiator: writes LFSR data to scratch registers, reads each one back
// and checks the c2 response, tracking up to MAX_OUT outstanding reads by tid.
module mmio_stress_requester
    import mmio_stress_pkg::*;
#(
    parameter int          MAX_OUT   = 4,
    parameter logic [15:0] BASE_ADDR = 16'h0010,
    parameter int          TIMEOUT   = 1024,
    parameter logic [63:0] LFSR_SEED = 64'h1
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset_n,
    input  logic        start,
    input  logic [15:0] num_ops,
    output logic        req_wr_valid,
    output logic        req_rd_valid,
    output logic [15:0] req_addr,
    output logic [1:0]  req_len,
    output logic [8:0]  req_tid,
    output logic [63:0] req_data,
    input  logic        rsp_valid,
    input  logic [8:0]  rsp_tid,
    input  logic [63:0] rsp_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] ops_done
);

    localparam int SLOT_LOG = $clog2(MAX_OUT);
    localparam int IDX_W    = (SLOT_LOG > 0) ? SLOT_LOG : 1;
    localparam int WD_W     = $clog2(TIMEOUT + 1);

    if (MAX_OUT < 1 || MAX_OUT > 64 || (MAX_OUT & (MAX_OUT - 1)) != 0) begin : g_bad_max_out
        $error("mmio_stress_requester: MAX_OUT must be a power of 2 in 1..64");
    end
    if (int'(BASE_ADDR) + 2 * (MAX_OUT - 1) >= 65536) begin : g_bad_addr_range
        $error("mmio_stress_requester: scratch region overflows 16-bit dword address");
    end
    if (BASE_ADDR < 16'd6) begin : g_bad_base
        $error("mmio_stress_requester: BASE_ADDR overlaps the AFU ID registers");
    end

    t_req_state          state, stateNext;
    t_slot               slots [MAX_OUT];
    t_slot               slotsNext [MAX_OUT];
    logic [IDX_W-1:0]    curSlot, curSlotNext;
    logic [15:0]         issued, issuedNext;
    logic [15:0]         numOpsQ, numOpsNext;
    logic [15:0]         errNext, opsNext;
    logic [WD_W-1:0]     wdCnt, wdNext;
    logic                doneNext, passNext;
    logic                wrValidNext, rdValidNext;
    logic [15:0]         addrNext;
    t_mmio_len           lenNext;
    logic [8:0]          tidNext;
    logic [63:0]         dataNext;
    logic                lfsrAdvance;
    logic [63:0]         lfsrOut;

    logic                freeFound, hit, anyValid, dataOk;
    logic [IDX_W-1:0]    freeIdx, hitIdx;
    logic                respActive, retire, timeoutHit;
    logic [8:0]          tidCalc;

    mmio_stress_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (pck_cp2af_softReset_n),
        .advance               (lfsrAdvance),
        .value                 (lfsrOut)
    );

    assign busy = state inside {ST_WR, ST_RD, ST_DRAIN};

    // NOTE: every variable is given a default before any branch, so no latch can be inferred.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        hit       = 1'b0;
        hitIdx    = '0;
        anyValid  = 1'b0;
        // Descending scan so the lowest free index wins.
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                freeFound = 1'b1;
                freeIdx   = IDX_W'(i);
            end
            if (slots[i].valid && slots[i].tid == rsp_tid) begin
                hit    = 1'b1;
                hitIdx = IDX_W'(i);
            end
            anyValid = anyValid | slots[i].valid;
        end

        dataOk = (slots[hitIdx].len == LEN64) ? (rsp_data == slots[hitIdx].exp_data)
                                              : (rsp_data[31:0] == slots[hitIdx].exp_data[31:0]);
        tidCalc    = 9'((issued << SLOT_LOG) | 16'(curSlot));
        respActive = (state != ST_IDLE);
        retire     = respActive && rsp_valid && hit;
        timeoutHit = respActive && anyValid && !rsp_valid && (wdCnt == WD_W'(TIMEOUT - 1));

        stateNext   = state;
        slotsNext   = slots;
        curSlotNext = curSlot;
        issuedNext  = issued;
        numOpsNext  = numOpsQ;
        errNext     = err_count;
        opsNext     = ops_done;
        doneNext    = done;
        passNext    = pass;
        wrValidNext = 1'b0;
        rdValidNext = 1'b0;
        addrNext    = '0;
        lenNext     = LEN32;
        tidNext     = '0;
        dataNext    = '0;
        lfsrAdvance = 1'b0;

        if (!respActive || rsp_valid || !anyValid) begin
            wdNext = '0;
        end else begin
            wdNext = wdCnt + WD_W'(1);
        end

        if (retire) begin
            slotsNext[hitIdx].valid = 1'b0;
            opsNext = ops_done + 16'd1;
        end
        if (((respActive && rsp_valid && !(hit && dataOk)) || timeoutHit) && err_count != 16'hFFFF) begin
            errNext = err_count + 16'd1;
        end

        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    errNext    = '0;
                    opsNext    = '0;
                    issuedNext = '0;
                    numOpsNext = num_ops;
                    if (num_ops == 16'd0) begin
                        stateNext = ST_DONE;
                        doneNext  = 1'b1;
                        passNext  = 1'b1;
                    end else begin
                        stateNext = ST_WR;
                        doneNext  = 1'b0;
                        passNext  = 1'b0;
                    end
                end
            end
            ST_WR: begin
                if (freeFound) begin
                    wrValidNext = 1'b1;
                    addrNext    = BASE_ADDR + {15'(freeIdx), 1'b0};
                    lenNext     = lfsrOut[0] ? LEN64 : LEN32;
                    dataNext    = lfsrOut[0] ? lfsrOut : {32'h0, lfsrOut[31:0]};
                    slotsNext[freeIdx].len      = lenNext;
                    slotsNext[freeIdx].exp_data = dataNext;
                    curSlotNext = freeIdx;
                    lfsrAdvance = 1'b1;
                    stateNext   = ST_RD;
                end
            end
            ST_RD: begin
                rdValidNext = 1'b1;
                addrNext    = BASE_ADDR + {15'(curSlot), 1'b0};
                lenNext     = slots[curSlot].len;
                tidNext     = tidCalc;
                slotsNext[curSlot].valid = 1'b1;
                slotsNext[curSlot].tid   = tidCalc;
                issuedNext  = issued + 16'd1;
                stateNext   = (issuedNext == numOpsQ) ? ST_DRAIN : ST_WR;
            end
            ST_DRAIN: begin
                if (!anyValid) begin
                    stateNext = ST_DONE;
                    doneNext  = 1'b1;
                    passNext  = (errNext == 16'd0);
                end
            end
            default: stateNext = ST_IDLE;
        endcase

        // Watchdog expiry abandons the outstanding reads and ends the run as a failure.
        if (timeoutHit) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                slotsNext[i].valid = 1'b0;
            end
            stateNext   = ST_DONE;
            doneNext    = 1'b1;
            passNext    = 1'b0;
            wrValidNext = 1'b0;
            rdValidNext = 1'b0;
            addrNext    = '0;
            lenNext     = LEN32;
            tidNext     = '0;
            dataNext    = '0;
            lfsrAdvance = 1'b0;
        end
    end

    always_ff @(posedge pClk) begin
        if (!pck_cp2af_softReset_n) begin
            state <= ST_IDLE;
            // NOTE: the slot table is a handful of flops, so whole entries are cleared, not just valid bits.
            for (int i = 0; i < MAX_OUT; i++) begin
                slots[i] <= '0;
            end
            curSlot      <= '0;
            issued       <= '0;
            numOpsQ      <= '0;
            err_count    <= '0;
            ops_done     <= '0;
            wdCnt        <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            req_wr_valid <= 1'b0;
            req_rd_valid <= 1'b0;
            req_addr     <= '0;
            req_len      <= '0;
            req_tid      <= '0;
            req_data     <= '0;
        end else begin
            state        <= stateNext;
            slots        <= slotsNext;
            curSlot      <= curSlotNext;
            issued       <= issuedNext;
            numOpsQ      <= numOpsNext;
            err_count    <= errNext;
            ops_done     <= opsNext;
            wdCnt        <= wdNext;
            done         <= doneNext;
            pass         <= passNext;
            req_wr_valid <= wrValidNext;
            req_rd_valid <= rdValidNext;
            req_addr     <= addrNext;
            req_len      <= lenNext;
            req_tid      <= tidNext;
            req_data     <= dataNext;
        end
    end

endmodule

// File: tb/tb_mmio_stress_requester.sv
// Bench for mmio_stress_requester: a scratch-register AFU model answers reads two cycles later,
// with optional fault injection, plus directed checks of the run results.
module tb_mmio_stress_requester;

    localparam int LAT = 2;

    logic        pClk = 1'b0;
    logic        rstN;
    logic        start;
    logic [15:0] numOps;
    logic        reqWr, reqRd;
    logic [15:0] reqAddr;
    logic [1:0]  reqLen;
    logic [8:0]  reqTid;
    logic [63:0] reqData;
    logic        rspValid;
    logic [8:0]  rspTid;
    logic [63:0] rspData;
    logic        busy, done, pass;
    logic [15:0] errCount, opsDone;

    int nChecks = 0;
    int nPass   = 0;

    always #5 pClk = ~pClk;

    mmio_stress_requester #(
        .MAX_OUT   (4),
        .BASE_ADDR (16'h0010),
        .TIMEOUT   (16),
        .LFSR_SEED (64'h1)
    ) dut (
        .pClk                  (pClk),
        .pck_cp2af_softReset_n (rstN),
        .start                 (start),
        .num_ops               (numOps),
        .req_wr_valid          (reqWr),
        .req_rd_valid          (reqRd),
        .req_addr              (reqAddr),
        .req_len               (reqLen),
        .req_tid               (reqTid),
        .req_data              (reqData),
        .rsp_valid             (rspValid),
        .rsp_tid               (rspTid),
        .rsp_data              (rspData),
        .busy                  (busy),
        .done                  (done),
        .pass                  (pass),
        .err_count             (errCount),
        .ops_done              (opsDone)
    );

    // ---------------- scratch-register AFU model ----------------
    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } t_pend;

    typedef struct {
        logic [15:0] addr;
        logic [1:0]  len;
        logic [8:0]  tid;
        logic [63:0] data;
    } t_req;

    t_pend       pend[$];
    t_req        wrLog[$];
    t_req        rdLog[$];
    logic [63:0] mem [logic [15:0]];
    int          cyc = 0;
    int          wrPulses = 0, rdPulses = 0, rd32 = 0, bothHigh = 0, rspCount = 0;
    int          flipNth = 0;
    bit          dropAll = 1'b0;
    logic        mdlValid = 1'b0;
    logic [8:0]  mdlTid = '0;
    logic [63:0] mdlData = '0;
    logic        injValid = 1'b0;
    logic [8:0]  injTid = '0;
    logic [63:0] rdWord;
    t_pend       head;

    assign rspValid = mdlValid | injValid;
    assign rspTid   = injValid ? injTid : mdlTid;
    assign rspData  = mdlData;

    always @(posedge pClk) cyc <= cyc + 1;

    always @(negedge pClk) begin
        mdlValid = 1'b0;
        mdlTid   = '0;
        mdlData  = '0;
        if (!rstN) begin
            pend.delete();
        end else begin
            if (reqWr && reqRd) bothHigh++;
            if (reqWr) begin
                wrPulses++;
                mem[reqAddr] = reqData;
                wrLog.push_back('{reqAddr, reqLen, reqTid, reqData});
            end
            if (reqRd) begin
                rdPulses++;
                rdWord = mem.exists(reqAddr) ? mem[reqAddr] : 64'h0;
                if (reqLen == 2'b00) begin
                    rdWord[63:32] = 32'hDEAD_BEEF;
                    rd32++;
                end
                rdLog.push_back('{reqAddr, reqLen, reqTid, rdWord});
                if (!dropAll) pend.push_back('{reqTid, rdWord, cyc + LAT});
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                head = pend.pop_front();
                rspCount++;
                mdlValid = 1'b1;
                mdlTid   = head.tid;
                mdlData  = (rspCount == flipNth) ? (head.data ^ 64'h20) : head.data;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic kick(input logic [15:0] n);
        @(negedge pClk);
        numOps = n;
        start  = 1'b1;
        @(negedge pClk);
        start  = 1'b0;
    endtask

    task automatic runOps(input string tag, input logic [15:0] n, input int budget, output int edges);
        kick(n);
        edges = 0;
        while (!done && edges < budget) begin
            @(negedge pClk);
            edges++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    int edges;
    int wrBefore, rdBefore;

    initial begin
        rstN   = 1'b0;
        start  = 1'b0;
        numOps = '0;
        repeat (3) @(posedge pClk);
        @(negedge pClk);

        // Reset state
        check("rst_flags", {61'b0, busy, done, pass}, 64'd0);
        check("rst_counts", {32'b0, errCount, opsDone}, 64'd0);
        check("rst_req", {reqWr, reqRd, reqAddr, reqLen, reqTid}, 64'd0);
        check("rst_data", reqData, 64'd0);
        rstN = 1'b1;

        // Loopback, 100 ops; model returns garbage in [63:32] of every 32-bit read
        wrLog.delete();
        rdLog.delete();
        rd32 = 0;
        runOps("a", 16'd100, 400, edges);
        check("a_within_250", 64'(edges <= 250), 64'd1);
        check("a_pass", 64'(pass), 64'd1);
        check("a_err", 64'(errCount), 64'd0);
        check("a_ops", 64'(opsDone), 64'd100);
        check("a_busy", 64'(busy), 64'd0);
        check("a_nwr", 64'(wrLog.size()), 64'd100);
        check("a_nrd", 64'(rdLog.size()), 64'd100);
        check("a_wr0", {wrLog[0].addr, 46'b0, wrLog[0].len}, {16'h0010, 48'h1});
        check("a_wr0_data", wrLog[0].data, 64'h1);
        check("a_wr1", {wrLog[1].addr, 46'b0, wrLog[1].len}, {16'h0012, 48'h0});
        check("a_wr1_data", wrLog[1].data, 64'h0);
        check("a_rd0", {rdLog[0].addr, rdLog[0].len, 37'b0, rdLog[0].tid}, {16'h0010, 2'b01, 46'h0});
        check("a_rd1", {rdLog[1].addr, rdLog[1].len, 37'b0, rdLog[1].tid}, {16'h0012, 2'b00, 46'h5});
        check("a_rd32_seen", 64'(rd32 > 0), 64'd1);

        // num_ops = 0: done/pass one cycle after start, no requests
        wrBefore = wrPulses;
        rdBefore = rdPulses;
        runOps("b", 16'd0, 4, edges);
        check("b_latency", 64'(edges), 64'd0);
        check("b_pass", 64'(pass), 64'd1);
        repeat (5) @(negedge pClk);
        check("b_no_req", 64'((wrPulses - wrBefore) + (rdPulses - rdBefore)), 64'd0);
        check("b_busy", 64'(busy), 64'd0);

        // Bit 5 flipped on the 3rd response of a 10-op run
        flipNth = rspCount + 3;
        runOps("c", 16'd10, 200, edges);
        flipNth = 0;
        check("c_err", 64'(errCount), 64'd1);
        check("c_pass", 64'(pass), 64'd0);
        check("c_ops", 64'(opsDone), 64'd10);

        // All responses dropped: watchdog ends the run
        dropAll = 1'b1;
        runOps("e", 16'd2, 100, edges);
        dropAll = 1'b0;
        check("e_latency", 64'(edges), 64'd18);
        check("e_err", 64'(errCount), 64'd1);
        check("e_pass", 64'(pass), 64'd0);
        check("e_busy", 64'(busy), 64'd0);
        check("e_ops", 64'(opsDone), 64'd0);

        // Reset mid-run, then a stale response
        kick(16'd20);
        for (int i = 0; i < 200 && opsDone < 16'd5; i++) @(negedge pClk);
        check("f_reached5", 64'(opsDone >= 16'd5), 64'd1);
        rstN = 1'b0;
        repeat (2) @(negedge pClk);
        rstN     = 1'b1;
        injValid = 1'b1;
        injTid   = 9'd1;
        @(negedge pClk);
        injValid = 1'b0;
        @(negedge pClk);
        check("f_flags", {61'b0, busy, done, pass}, 64'd0);
        check("f_counts", {32'b0, errCount, opsDone}, 64'd0);
        check("f_req", {reqWr, reqRd, reqAddr, reqLen, reqTid}, 64'd0);
        runOps("f2", 16'd4, 100, edges);
        check("f2_pass", 64'(pass), 64'd1);
        check("f2_err", 64'(errCount), 64'd0);
        check("f2_ops", 64'(opsDone), 64'd4);

        check("one_valid_per_cycle", 64'(bothHigh), 64'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
